// File: rtl/comp2_4bit_core.sv
// Registered two's-complement negator: accepts one operand per cycle and
// returns -I along with most-negative and zero flags one cycle later.
module comp2_4bit_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I,
    input  logic             in_valid,
    output logic [WIDTH-1:0] O,
    output logic             out_valid,
    output logic             ovf,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Handshake: a sample happens on any rising edge with in_valid=1 (and
    // rst_n=1); out_valid then pulses for exactly the following cycle.
    // There is no backpressure, so results are never stalled.

    logic [WIDTH-1:0] o_q, o_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    always_comb begin
        o_d     = o_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        if (in_valid) begin
            // Carry out of the increment is dropped, so 1000 maps to itself.
            o_d     = ~I + ONE;
            ovf_d   = (I == MOST_NEG);
            zero_d  = (I == '0);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q     <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            o_q     <= o_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign O         = o_q;
    assign out_valid = valid_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_comp2_4bit_core.sv
// Directed plus randomized bench for comp2_4bit_core, checked against an
// arithmetic model of negation modulo 16.
module tb_comp2_4bit_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] I = 4'd0;
    logic       in_valid = 1'b0;
    logic [3:0] O;
    logic       out_valid;
    logic       ovf;
    logic       zero;

    int tests = 0;
    int fails = 0;

    logic [3:0] exp_o = 4'd0;
    logic       exp_valid = 1'b0;
    logic       exp_ovf = 1'b0;
    logic       exp_zero = 1'b0;

    comp2_4bit_core #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .I         (I),
        .in_valid  (in_valid),
        .O         (O),
        .out_valid (out_valid),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: negation as 16 - I modulo 16; flags from the value alone.
    task automatic model(input logic r, input logic v, input logic [3:0] x);
        int n;
        if (!r) begin
            exp_o = 4'd0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_zero = 1'b0;
        end else if (v) begin
            n = (16 - int'(x)) % 16;
            exp_o     = n[3:0];
            exp_valid = 1'b1;
            exp_ovf   = (int'(x) == 8);
            exp_zero  = (int'(x) == 0);
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic check(input string tag);
        tests++;
        assert (O === exp_o) else begin
            fails++; $error("FAIL %s O got %b want %b", tag, O, exp_o);
        end
        tests++;
        assert (out_valid === exp_valid) else begin
            fails++; $error("FAIL %s out_valid got %b want %b", tag, out_valid, exp_valid);
        end
        tests++;
        assert (ovf === exp_ovf) else begin
            fails++; $error("FAIL %s ovf got %b want %b", tag, ovf, exp_ovf);
        end
        tests++;
        assert (zero === exp_zero) else begin
            fails++; $error("FAIL %s zero got %b want %b", tag, zero, exp_zero);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [3:0] x, input string tag);
        @(negedge clk);
        rst_n = r; in_valid = v; I = x;
        @(posedge clk);
        #1;
        model(r, v, x);
        check(tag);
    endtask

    initial begin
        logic [3:0] first;
        logic [3:0] x;
        logic       r;
        logic       v;

        // Reset with an operand presented: must be discarded.
        step(1'b0, 1'b1, 4'b0101, "reset");
        step(1'b0, 1'b0, 4'b0000, "reset_hold");

        // First operand right after reset, then exhaustive back-to-back sweep.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'(i), "sweep");

        // Flag boundaries.
        step(1'b1, 1'b1, 4'b1000, "most_neg");
        tests++;
        assert (O === 4'b1000 && ovf === 1'b1 && zero === 1'b0) else begin
            fails++; $error("FAIL most_neg_const got O=%b ovf=%b zero=%b want 1000 1 0", O, ovf, zero);
        end
        step(1'b1, 1'b1, 4'b0000, "zero_in");
        step(1'b1, 1'b1, 4'b0101, "mid_val");
        tests++;
        assert (O === 4'b1011 && ovf === 1'b0 && zero === 1'b0) else begin
            fails++; $error("FAIL mid_val_const got O=%b ovf=%b zero=%b want 1011 0 0", O, ovf, zero);
        end

        // Hold: accept 0011 then idle with a different I.
        step(1'b1, 1'b1, 4'b0011, "hold_load");
        step(1'b1, 1'b0, 4'b1111, "hold_idle");
        tests++;
        assert (O === 4'b1101 && out_valid === 1'b0) else begin
            fails++; $error("FAIL hold_const got O=%b v=%b want 1101 0", O, out_valid);
        end

        // A glitch on rst_n between edges must not disturb the outputs.
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        #1 check("async_glitch");

        // Reset mid-stream.
        step(1'b1, 1'b1, 4'b0110, "mid_load");
        step(1'b0, 1'b1, 4'b0001, "mid_reset");
        step(1'b1, 1'b1, 4'b0001, "post_reset");
        tests++;
        assert (O === 4'b1111 && out_valid === 1'b1) else begin
            fails++; $error("FAIL post_reset_const got O=%b v=%b want 1111 1", O, out_valid);
        end

        // Involution: feed each result back in.
        for (int i = 0; i < 16; i++) begin
            first = 4'(i);
            step(1'b1, 1'b1, first, "invol_a");
            x = O;
            step(1'b1, 1'b1, x, "invol_b");
            tests++;
            assert (O === first) else begin
                fails++; $error("FAIL involution got %b want %b", O, first);
            end
        end

        // Random traffic with occasional idles and resets.
        for (int k = 0; k < 60; k++) begin
            r = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 3) != 0);
            x = 4'($urandom_range(0, 15));
            step(r, v, x, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/comp2_4bit_core.md
COMP2_4BIT_CORE -- requirements
Module: comp2_4bit

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; all requirements below are stated for WIDTH=4.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-004 Port I  input  WIDTH  operand, unsigned bit pattern; I[3] is the MSB.
REQ-005 Port in_valid  input  1  operand qualifier; I is sampled only when in_valid=1.
REQ-006 Port O  output  WIDTH  registered two's complement of the last accepted I.
REQ-007 Port out_valid  output  1  high for exactly one cycle per accepted operand.
REQ-008 Port ovf  output  1  registered flag; set when the accepted I is the most-negative value (1000).
REQ-009 Port zero  output  1  registered flag; set when the accepted I is 0000.

Function
REQ-010 Result: O SHALL equal (~I + 1) mod 2^WIDTH, i.e. bitwise inversion plus one with the carry-out discarded.
REQ-011 Latency: when in_valid=1 at rising edge N (with rst_n=1), O, ovf, zero SHALL reflect that I after edge N, and out_valid SHALL be 1 for the cycle following edge N.
REQ-012 Idle: when in_valid=0 at an edge, O/ovf/zero SHALL hold their previous values and out_valid SHALL be 0.
REQ-013 Throughput: one operand per cycle; back-to-back in_valid=1 cycles SHALL produce back-to-back results with no bubbles.
REQ-014 Boundary 0000: O=0000, zero=1, ovf=0.
REQ-015 Boundary 1000: O=1000 (self-negating), ovf=1, zero=0.
REQ-016 Boundary 0111: O=1001; 1111: O=0001; 0001: O=1111; ovf=0 and zero=0 for all of these.
REQ-017 ovf and zero SHALL be mutually exclusive; both SHALL be 0 for every I other than 1000 and 0000 respectively.
REQ-018 Mapping: the full 16-entry truth table SHALL hold: 0000->0000, 0001->1111, 0010->1110, 0011->1101, 0100->1100, 0101->1011, 0110->1010, 0111->1001, 1000->1000, 1001->0111, 1010->0110, 1011->0101, 1100->0100, 1101->0011, 1110->0010, 1111->0001.
REQ-019 The logic SHALL contain no combinational path from any input to any output; all outputs come directly from flops.
REQ-020 Applying the operation twice SHALL return the original operand for every input value.

Reset
REQ-021 When rst_n=0 at a rising edge: O=0000, out_valid=0, ovf=0, zero=0 after that edge, regardless of in_valid or I.
REQ-022 Reset SHALL take priority over in_valid; an operand presented in a reset cycle SHALL be discarded and SHALL produce no out_valid.
REQ-023 The first accepted operand after rst_n returns high SHALL follow REQ-011 with no extra latency.
REQ-024 rst_n SHALL have no effect between clock edges, because reset is synchronous.

Verification
REQ-025 Exhaustive sweep: drive I=0000..1111 with in_valid=1 on consecutive cycles -> each result matches REQ-018 one cycle later, with out_valid=1 on all 16 cycles.
REQ-026 Flags: I=1000 -> O=1000, ovf=1, zero=0; I=0000 -> O=0000, zero=1, ovf=0; I=0101 -> O=1011, both flags 0.
REQ-027 Hold: accept I=0011 (O=1101), then drop in_valid and change I to 1111 -> O stays 1101 and out_valid=0.
REQ-028 Reset mid-stream: accept I=0110 and assert rst_n=0 on the next edge with in_valid=1, I=0001 -> O=0000, out_valid=0, flags 0; release reset and accept I=0001 -> O=1111 one cycle later.
REQ-029 Involution: feed O back to I for all 16 values -> the second result equals the original operand.
